// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix lines and decoded key event bundle
interface keypad_scanner_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       key_strobe;
    logic [3:0] key_code;
    logic       is_dig;
    logic       is_op;
    logic       is_enter;
    logic       is_result;

    modport master (
        input  rows,
        output cols, key_strobe, key_code, is_dig, is_op, is_enter, is_result
    );

    modport slave (
        output rows,
        input  cols, key_strobe, key_code, is_dig, is_op, is_enter, is_result
    );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with row debounce and key encoding
module keypad_scanner #(
    parameter int SCAN_DIV         = 1000,
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic              clk,
    input  logic              nrst,
    keypad_scanner_if.master  kp
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_TARGET = DEB_W'(DEBOUNCE_SAMPLES);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_FIRE     = 2'd2;
    localparam logic [1:0] ST_HOLD     = 2'd3;

    logic [1:0]       r_state;
    logic [3:0]       r_cols;
    logic [DIV_W-1:0] r_div;
    logic [DEB_W-1:0] r_deb;
    logic [3:0]       r_meta;
    logic [3:0]       r_rs;
    logic [3:0]       r_pat;
    logic             r_strobe;
    logic [3:0]       r_code;
    logic             r_dig;
    logic             r_op;
    logic             r_enter;
    logic             r_result;

    logic             w_sample;
    logic             w_onehot;
    logic             w_fire;
    logic [3:0]       w_rot;
    logic [DEB_W-1:0] w_deb_next;
    logic [1:0]       w_row;
    logic [1:0]       w_col;
    logic [3:0]       w_code;

    assign w_sample   = (r_div == DIV_LAST);
    assign w_onehot   = (r_rs != 4'b0) && ((r_rs & (r_rs - 4'd1)) == 4'b0);
    assign w_rot      = {r_cols[2:0], r_cols[3]};
    assign w_deb_next = r_deb + 1'b1;

    // Entering FIRE: outputs load on the same edge so the strobe coincides with the FIRE cycle.
    assign w_fire = w_sample && w_onehot &&
                    (((r_state == ST_SCAN) && (DEBOUNCE_SAMPLES == 1)) ||
                     ((r_state == ST_DEBOUNCE) && (r_rs == r_pat) && (w_deb_next == DEB_TARGET)));

    always_comb begin
        w_row = 2'd0;
        w_col = 2'd0;
        case (r_rs)
            4'b0010: w_row = 2'd1;
            4'b0100: w_row = 2'd2;
            4'b1000: w_row = 2'd3;
            default: w_row = 2'd0;
        endcase
        case (r_cols)
            4'b0010: w_col = 2'd1;
            4'b0100: w_col = 2'd2;
            4'b1000: w_col = 2'd3;
            default: w_col = 2'd0;
        endcase
        if (w_col == 2'd3)
            w_code = 4'hA + {2'b00, w_row};
        else if (w_row == 2'd3)
            w_code = (w_col == 2'd0) ? 4'hE : ((w_col == 2'd1) ? 4'h0 : 4'hF);
        else
            w_code = {2'b00, w_row} * 4'd3 + {2'b00, w_col} + 4'd1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state  <= ST_SCAN;
            r_cols   <= 4'b0001;
            r_div    <= '0;
            r_deb    <= '0;
            r_meta   <= 4'b0;
            r_rs     <= 4'b0;
            r_pat    <= 4'b0;
            r_strobe <= 1'b0;
            r_code   <= 4'b0;
            r_dig    <= 1'b0;
            r_op     <= 1'b0;
            r_enter  <= 1'b0;
            r_result <= 1'b0;
        end else begin
            r_meta   <= kp.rows;
            r_rs     <= r_meta;
            r_div    <= w_sample ? '0 : r_div + 1'b1;
            r_strobe <= w_fire;
            r_code   <= w_fire ? w_code : 4'b0;
            r_dig    <= w_fire && (w_code <= 4'd9);
            r_op     <= w_fire && (w_code >= 4'hA);
            r_enter  <= w_fire && (w_code == 4'hF);
            r_result <= w_fire && (w_code == 4'hE);
            case (r_state)
                ST_SCAN: if (w_sample) begin
                    if (w_onehot) begin
                        r_pat   <= r_rs;
                        r_deb   <= DEB_W'(1);
                        r_state <= (DEBOUNCE_SAMPLES == 1) ? ST_FIRE : ST_DEBOUNCE;
                    end else begin
                        r_cols  <= w_rot;
                    end
                end
                ST_DEBOUNCE: if (w_sample) begin
                    if (r_rs == r_pat) begin
                        r_deb <= w_deb_next;
                        if (w_deb_next == DEB_TARGET)
                            r_state <= ST_FIRE;
                    end else begin
                        r_deb   <= '0;
                        r_state <= ST_SCAN;
                    end
                end
                ST_FIRE: begin
                    r_deb   <= '0;
                    r_state <= ST_HOLD;
                end
                ST_HOLD: if (w_sample) begin
                    // Any activity on the held column restarts the release count.
                    if (r_rs != 4'b0) begin
                        r_deb <= '0;
                    end else if (w_deb_next == DEB_TARGET) begin
                        r_deb   <= '0;
                        r_cols  <= w_rot;
                        r_state <= ST_SCAN;
                    end else begin
                        r_deb <= w_deb_next;
                    end
                end
                default: r_state <= ST_SCAN;
            endcase
        end
    end

    assign kp.cols       = r_cols;
    assign kp.key_strobe = r_strobe;
    assign kp.key_code   = r_code;
    assign kp.is_dig     = r_dig;
    assign kp.is_op      = r_op;
    assign kp.is_enter   = r_enter;
    assign kp.is_result  = r_result;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;
    logic clk;
    logic nrst;

    keypad_scanner_if ifc ();

    keypad_scanner #(
        .SCAN_DIV         (4),
        .DEBOUNCE_SAMPLES (3)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .kp   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       force_en   = 1'b0;
    logic [3:0] force_rows = 4'b0;
    logic [3:0] press_col  = 4'b0;
    logic [3:0] press_row  = 4'b0;

    // Physical keypad: a pressed key connects its column drive to its row line.
    always_comb
        ifc.rows = force_en ? force_rows :
                   (((ifc.cols & press_col) != 4'b0) ? press_row : 4'b0);

    int         n_strobes   = 0;
    logic       prev_strobe = 1'b0;
    logic [3:0] cap_code    = 4'b0;
    logic       cap_dig     = 1'b0;
    logic       cap_op      = 1'b0;
    logic       cap_enter   = 1'b0;
    logic       cap_result  = 1'b0;

    always @(negedge clk) begin
        if (ifc.key_strobe === 1'b1) begin
            n_strobes  = n_strobes + 1;
            cap_code   = ifc.key_code;
            cap_dig    = ifc.is_dig;
            cap_op     = ifc.is_op;
            cap_enter  = ifc.is_enter;
            cap_result = ifc.is_result;
            checks = checks + 1;
            assert (prev_strobe === 1'b0) else begin
                errors = errors + 1;
                $error("FAIL strobe_back_to_back observed=%0b expected=0", prev_strobe);
            end
        end else begin
            checks = checks + 1;
            assert ({ifc.key_code, ifc.is_dig, ifc.is_op, ifc.is_enter, ifc.is_result} === 8'h00) else begin
                errors = errors + 1;
                $error("FAIL idle_outputs observed=%0h expected=0",
                       {ifc.key_code, ifc.is_dig, ifc.is_op, ifc.is_enter, ifc.is_result});
            end
        end
        prev_strobe = ifc.key_strobe;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic press_key(input logic [3:0] col, input logic [3:0] row, output int got);
        int base;
        base      = n_strobes;
        press_col = col;
        press_row = row;
        for (int i = 0; i < 60 && n_strobes == base; i++) tick();
        repeat (8) tick();
        got       = n_strobes - base;
        press_row = 4'b0;
        repeat (30) tick();
    endtask

    initial begin
        int base;
        int got;
        int n;
        logic [3:0] seen;

        nrst = 1'b1;
        #1 nrst = 1'b0;
        repeat (3) tick();
        nrst = 1'b1;
        repeat (5) tick();

        // 1: asynchronous reset mid-clock with a row active
        @(posedge clk);
        #3;
        force_en   = 1'b1;
        force_rows = 4'b0010;
        nrst       = 1'b0;
        #1;
        check("reset_cols",      ifc.cols,       4'b0001);
        check("reset_strobe",    ifc.key_strobe, 1'b0);
        check("reset_code",      ifc.key_code,   4'h0);
        check("reset_is_dig",    ifc.is_dig,     1'b0);
        check("reset_is_op",     ifc.is_op,      1'b0);
        check("reset_is_enter",  ifc.is_enter,   1'b0);
        check("reset_is_result", ifc.is_result,  1'b0);
        repeat (2) tick();
        force_rows = 4'b0;
        nrst       = 1'b1;
        base       = n_strobes;
        repeat (100) tick();
        check("idle_no_strobe", n_strobes - base, 0);
        force_en = 1'b0;

        // 2: digit 6 at r1/c2, held 40 cycles, then release timing
        base      = n_strobes;
        press_col = 4'b0100;
        press_row = 4'b0010;
        repeat (40) tick();
        check("dig6_count",  n_strobes - base, 1);
        check("dig6_code",   cap_code, 4'h6);
        check("dig6_is_dig", cap_dig,  1'b1);
        check("dig6_is_op",  cap_op,   1'b0);
        press_row = 4'b0;
        n = 0;
        while (ifc.cols == 4'b0100 && n < 40) begin
            tick();
            n++;
        end
        check("release_next_col", ifc.cols, 4'b1000);
        check("release_latency_window", (n >= 11 && n <= 14), 1'b1);
        repeat (10) tick();

        // 3: enter and result keys
        press_key(4'b0100, 4'b1000, got);
        check("enter_count",     got,        1);
        check("enter_code",      cap_code,   4'hF);
        check("enter_is_op",     cap_op,     1'b1);
        check("enter_is_enter",  cap_enter,  1'b1);
        check("enter_is_result", cap_result, 1'b0);
        check("enter_is_dig",    cap_dig,    1'b0);
        press_key(4'b0001, 4'b1000, got);
        check("result_count",     got,        1);
        check("result_code",      cap_code,   4'hE);
        check("result_is_op",     cap_op,     1'b1);
        check("result_is_result", cap_result, 1'b1);
        check("result_is_enter",  cap_enter,  1'b0);

        // 4: bouncing contact on r2/c1, then a clean press
        base      = n_strobes;
        press_col = 4'b0010;
        for (int i = 0; i < 12; i++) begin
            press_row = (i % 2 == 0) ? 4'b0100 : 4'b0000;
            repeat (5) tick();
        end
        press_row = 4'b0;
        repeat (10) tick();
        check("bounce_no_strobe", n_strobes - base, 0);
        press_key(4'b0010, 4'b0100, got);
        check("key8_count",  got,      1);
        check("key8_code",   cap_code, 4'h8);
        check("key8_is_dig", cap_dig,  1'b1);

        // 5: two rows in the same column are ignored and scanning continues
        base      = n_strobes;
        press_col = 4'b0001;
        press_row = 4'b0011;
        seen      = 4'b0;
        repeat (60) begin
            tick();
            seen = seen | ifc.cols;
        end
        check("multikey_no_strobe", n_strobes - base, 0);
        check("multikey_cols_rotate", seen, 4'b1111);
        press_row = 4'b0;
        repeat (10) tick();

        // 6: reset after the second matching sample of r0/c0 discards the press
        nrst      = 1'b0;
        press_col = 4'b0001;
        press_row = 4'b0001;
        repeat (2) tick();
        base = n_strobes;
        nrst = 1'b1;
        repeat (9) tick();
        nrst = 1'b0;
        #1;
        check("middeb_no_strobe", n_strobes - base, 0);
        check("middeb_cols",      ifc.cols, 4'b0001);
        repeat (2) tick();
        nrst = 1'b1;
        repeat (40) tick();
        check("key1_count",  n_strobes - base, 1);
        check("key1_code",   cap_code, 4'h1);
        check("key1_is_dig", cap_dig,  1'b1);
        press_row = 4'b0;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage of the calculator control FSM.
- Scans a 4x4 matrix keypad, synchronises and debounces the row inputs, and encodes the pressed key.
- Emits one single-cycle key_strobe per physical press, with classification flags (is_dig, is_op, is_enter, is_result) and a 4-bit key_code.
- The FSM and the digit datapath consume these outputs directly.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven before its rows are sampled (dwell). Minimum 4.
- DEBOUNCE_SAMPLES, 4: consecutive identical samples required to accept a press or a release. Minimum 1.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- rows  in  4  keypad row sense, active-high, pulled low externally, asynchronous to clk
- cols  out  4  one-hot column drive, active-high
- key_strobe  out  1  one-cycle pulse when a debounced press is accepted
- key_code  out  4  encoded key, valid only while key_strobe=1, else 0
- is_dig  out  1  key is 0-9, valid with strobe, else 0
- is_op  out  1  key is A/B/C/D/#/*, valid with strobe, else 0
- is_enter  out  1  key is '#', valid with strobe, else 0
- is_result  out  1  key is '*', valid with strobe, else 0

Behaviour:
- Reset (asynchronous, nrst=0): state=SCAN, cols=4'b0001, dwell counter=0, debounce counter=0, synchroniser flops=0. All strobe/flag/code outputs=0. Deassertion takes effect on the next clk edge. Reset mid-debounce or mid-hold discards the press; no strobe is issued.
- rows pass through a 2-flop synchroniser; only the synchronised value (rs) is used.
- Key map (row r, col c) -> key_code:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: * (4'hE), 0, # (4'hF), D
- Flags:
  - is_dig=1 for codes 0-9.
  - is_op=1 for A, B, C, D, E, F.
  - is_enter=1 only for F.
  - is_result=1 only for E.
  - is_dig and is_op are mutually exclusive.
- Sampling: a sample is taken on the last cycle of each SCAN_DIV dwell.
- State SCAN:
  - Each dwell end with rs==0: rotate cols left (0001->0010->0100->1000->0001).
  - Dwell end with rs one-hot: latch column and row pattern, set debounce count=1, go to DEBOUNCE. If DEBOUNCE_SAMPLES==1, go straight to FIRE.
  - Dwell end with rs having more than one bit set (multi-key or ghost): ignore and rotate.
- State DEBOUNCE:
  - Column held; samples every SCAN_DIV cycles.
  - Sample equal to latched pattern: count+1. On reaching DEBOUNCE_SAMPLES, go to FIRE.
  - Any other sample (0, different, or multi-bit): return to SCAN on the same column. No strobe.
- State FIRE (exactly 1 cycle): key_strobe=1, key_code and flags driven from the latched row/column. Then go to HOLD with release count=0.
- State HOLD:
  - Column held; samples every SCAN_DIV cycles.
  - rs==0 increments the release count; any nonzero sample clears it.
  - Reaching DEBOUNCE_SAMPLES: rotate to the next column, go to SCAN.
  - A held key never re-strobes.
  - Other keys pressed while holding are ignored.
- Outputs are registered. key_strobe is never high on two consecutive cycles. The minimum gap between strobes is 2*DEBOUNCE_SAMPLES*SCAN_DIV cycles.
- Latency from a clean press to strobe: at most (4+DEBOUNCE_SAMPLES)*SCAN_DIV+3 cycles.
- Counters are sized from the parameters ($clog2). No overflow or wrap in any state.

Test Plan:
Bench uses SCAN_DIV=4, DEBOUNCE_SAMPLES=3.
1. Reset: nrst=0 mid-clock with rows=4'b0010 -> cols=0001 immediately, all outputs 0. Hold 2 cycles, release -> no strobe within 100 cycles while rows=0.
2. Digit: rows=0010 (r1) asserted only while cols=0100 (c2), held 40 cycles -> exactly one strobe, key_code=6, is_dig=1, is_op=0. Then rows=0 -> scan resumes at cols=1000 after 12 release cycles.
3. Enter/result: press r3/c2 -> key_code=F, is_op=1, is_enter=1, is_result=0. Press r3/c0 -> key_code=E, is_op=1, is_result=1, is_enter=0.
4. Bounce: rows toggle 0/0100 every 5 cycles during c1 -> no strobe. Then stable 0100 for 24 cycles -> one strobe, key_code=8.
5. Multi-key: rows=0011 in c0 -> no strobe; cols keeps rotating.
6. Reset mid-debounce: press r0/c0, assert nrst=0 after the 2nd matching sample -> no strobe, cols=0001. After release, a held key strobes key_code=1 exactly once.
